// File: rtl/pu_pkg.sv
// Shared definitions for the streaming processing-unit core: FSM encoding,
// activation-mode codes and a signed saturation helper.
package pu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_POST = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] ACT_BYPASS  = 2'd0;
  localparam logic [1:0] ACT_RELU    = 2'd1;
  localparam logic [1:0] ACT_CLIP    = 2'd2;
  localparam logic [1:0] ACT_BYPASS3 = 2'd3;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pu_mac_lane.sv
// One output channel: VEC-wide signed dot product, saturating accumulator,
// bias/shift/activation/saturation output stage. Honours PU_ROUND_EN.
module pu_mac_lane
  import pu_pkg::*;
#(
  parameter int VEC    = 5,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 8,
  parameter int ACT_BW = 8,
  parameter int BO_BW  = 8,
  parameter int AC_BW  = 24,
  parameter int SH_BW  = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           beat,
  input  logic                           post,
  input  logic [VEC-1:0][I_F_BW-1:0]     fmap,
  input  logic [VEC-1:0][W_BW-1:0]       weight,
  input  logic signed [B_BW-1:0]         bias,
  input  logic [SH_BW-1:0]               shift,
  input  logic [1:0]                     mode,
  input  logic [BO_BW-1:0]               bound,
  output logic signed [ACT_BW-1:0]       act,
  output logic                           sat
);

  function automatic logic signed [63:0] mul(input logic signed [I_F_BW-1:0] a,
                                             input logic signed [W_BW-1:0] b);
    logic signed [63:0] ax, bx;
    ax = 64'(a);
    bx = 64'(b);
    return ax * bx;
  endfunction

  logic signed [AC_BW-1:0] acc;
  logic signed [63:0] lane_sum, acc_full, acc_sat;
  logic signed [63:0] biased, shifted, actv, bnd, out_sat;
  logic               acc_clamp, out_clamp;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < VEC; i++) lane_sum = lane_sum + mul(fmap[i], weight[i]);
    acc_full  = lane_sum + 64'(acc);
    acc_sat   = sat_s(acc_full, AC_BW);
    acc_clamp = (acc_sat != acc_full);

    biased = 64'(acc) + 64'(bias);
`ifdef PU_ROUND_EN
    // Round half up: add half an output LSB before discarding bits.
    if (shift != '0) biased = biased + (64'sd1 <<< (shift - 1'b1));
`endif
    shifted = biased >>> shift;

    bnd  = $signed({{(64-BO_BW){1'b0}}, bound});
    actv = shifted;
    case (mode)
      ACT_RELU: if (shifted < 0) actv = '0;
      ACT_CLIP: begin
        if (shifted < 0)        actv = '0;
        else if (shifted > bnd) actv = bnd;
      end
      default: actv = shifted;
    endcase
    out_sat   = sat_s(actv, ACT_BW);
    out_clamp = (out_sat != actv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      act <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      sat <= 1'b0;
    end else begin
      if (beat) begin
        acc <= AC_BW'(acc_sat);
        if (acc_clamp) sat <= 1'b1;
      end
      if (post) begin
        act <= ACT_BW'(out_sat);
        if (out_clamp) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pu_stream_core.sv
// Streaming dot-product core: job FSM and beat counter driving LANES MAC lanes.
// Optional round-half-up requantisation when PU_ROUND_EN is defined.
module pu_stream_core
  import pu_pkg::*;
#(
  parameter int LANES  = 5,
  parameter int VEC    = 5,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 8,
  parameter int ACT_BW = 8,
  parameter int BO_BW  = 8,
  parameter int AC_BW  = 24,
  parameter int KL_BW  = 8,
  parameter int SH_BW  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [KL_BW-1:0]              i_k_len,
  input  logic [1:0]                    i_act_mode,
  input  logic [SH_BW-1:0]              i_shift,
  input  logic [BO_BW-1:0]              i_bound,
  input  logic [LANES*B_BW-1:0]         i_bias,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [VEC*I_F_BW-1:0]         i_fmap,
  input  logic [LANES*VEC*W_BW-1:0]     i_weight,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [LANES*ACT_BW-1:0]       o_act_data,
  output logic                          o_sat,
  output logic                          o_busy
);

  state_t                        state, state_nxt;
  logic [KL_BW-1:0]              k_len_q, cnt;
  logic [SH_BW-1:0]              shift_q;
  logic [1:0]                    mode_q;
  logic [BO_BW-1:0]              bound_q;
  logic [LANES-1:0][B_BW-1:0]    bias_q;
  logic [LANES-1:0][ACT_BW-1:0]  act_lane;
  logic [LANES-1:0]              lane_sat;
  logic                          start, beat, last;

  assign start = (state == S_IDLE) && i_start;
  assign beat  = (state == S_ACC) && i_valid;
  assign last  = (cnt == k_len_q - KL_BW'(1));

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b1;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = (i_k_len == '0) ? S_POST : S_ACC;
      end
      S_ACC: begin
        o_ready = 1'b1;
        if (i_valid && last) state_nxt = S_POST;
      end
      S_POST: state_nxt = S_OUT;
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k_len_q <= '0;
      cnt     <= '0;
      shift_q <= '0;
      mode_q  <= '0;
      bound_q <= '0;
      bias_q  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        k_len_q <= i_k_len;
        cnt     <= '0;
        shift_q <= i_shift;
        mode_q  <= i_act_mode;
        bound_q <= i_bound;
        bias_q  <= i_bias;
      end else if (beat) begin
        cnt <= cnt + KL_BW'(1);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pu_mac_lane #(
      .VEC(VEC), .I_F_BW(I_F_BW), .W_BW(W_BW), .B_BW(B_BW),
      .ACT_BW(ACT_BW), .BO_BW(BO_BW), .AC_BW(AC_BW), .SH_BW(SH_BW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start),
      .beat   (beat),
      .post   (state == S_POST),
      .fmap   (i_fmap),
      .weight (i_weight[l*VEC*W_BW +: VEC*W_BW]),
      .bias   (bias_q[l]),
      .shift  (shift_q),
      .mode   (mode_q),
      .bound  (bound_q),
      .act    (act_lane[l]),
      .sat    (lane_sat[l])
    );
  end

  assign o_act_data = act_lane;
  assign o_sat      = |lane_sat;

endmodule

// File: tb/tb_pu_stream_core.sv
// Table-driven self-checking bench for pu_stream_core with a result scoreboard.
// Build with PU_ROUND_EN defined to check the rounding variant.
module tb_pu_stream_core;
  localparam int LANES = 5, VEC = 5, I_F_BW = 8, W_BW = 8, B_BW = 8;
  localparam int ACT_BW = 8, BO_BW = 8, AC_BW = 24, KL_BW = 8, SH_BW = 5;
`ifdef PU_ROUND_EN
  localparam int RND_EXP = 3;
`else
  localparam int RND_EXP = 2;
`endif

  logic                      clk = 1'b0, rst_n = 1'b0;
  logic                      i_start = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [KL_BW-1:0]          i_k_len = '0;
  logic [1:0]                i_act_mode = '0;
  logic [SH_BW-1:0]          i_shift = '0;
  logic [BO_BW-1:0]          i_bound = '0;
  logic [LANES*B_BW-1:0]     i_bias = '0;
  logic [VEC*I_F_BW-1:0]     i_fmap = '0;
  logic [LANES*VEC*W_BW-1:0] i_weight = '0;
  logic                      o_ready, o_valid, o_sat, o_busy;
  logic [LANES*ACT_BW-1:0]   o_act_data;

  pu_stream_core #(
    .LANES(LANES), .VEC(VEC), .I_F_BW(I_F_BW), .W_BW(W_BW), .B_BW(B_BW),
    .ACT_BW(ACT_BW), .BO_BW(BO_BW), .AC_BW(AC_BW), .KL_BW(KL_BW), .SH_BW(SH_BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len),
    .i_act_mode(i_act_mode), .i_shift(i_shift), .i_bound(i_bound),
    .i_bias(i_bias), .i_valid(i_valid), .o_ready(o_ready), .i_fmap(i_fmap),
    .i_weight(i_weight), .o_valid(o_valid), .i_ready(i_ready),
    .o_act_data(o_act_data), .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int k, f, w, b, bstep, sh, mode, bound, bp, exp, estep, esat;
  } vec_t;

  typedef struct {
    logic [LANES*ACT_BW-1:0] data;
    logic                    sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  vec_t tbl[14];

  function automatic vec_t mk(string name, int k, int f, int w, int b, int bstep,
                              int sh, int mode, int bound, int bp, int exp,
                              int estep, int esat);
    vec_t v;
    v.name = name; v.k = k; v.f = f; v.w = w; v.b = b; v.bstep = bstep;
    v.sh = sh; v.mode = mode; v.bound = bound; v.bp = bp; v.exp = exp;
    v.estep = estep; v.esat = esat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic junk_inputs();
    i_k_len    = KL_BW'($urandom);
    i_act_mode = 2'($urandom);
    i_shift    = SH_BW'($urandom);
    i_bound    = BO_BW'($urandom);
    i_bias     = LANES*B_BW'({$urandom, $urandom});
    i_fmap     = VEC*I_F_BW'({$urandom, $urandom});
  endtask

  task automatic load_job(input vec_t v);
    i_k_len    = KL_BW'(v.k);
    i_act_mode = 2'(v.mode);
    i_shift    = SH_BW'(v.sh);
    i_bound    = BO_BW'(v.bound);
    for (int l = 0; l < LANES; l++) i_bias[l*B_BW +: B_BW] = B_BW'(v.b + l*v.bstep);
    for (int e = 0; e < VEC; e++) i_fmap[e*I_F_BW +: I_F_BW] = I_F_BW'(v.f);
    for (int e = 0; e < LANES*VEC; e++) i_weight[e*W_BW +: W_BW] = W_BW'(v.w);
  endtask

  // Start, stream k beats with random gaps while poking i_start and junking
  // the latched config, then check latency, result, back-pressure and handshake.
  task automatic run_job(input vec_t v);
    exp_t e, got;
    int   beats, guard, lat;
    load_job(v);
    for (int l = 0; l < LANES; l++) e.data[l*ACT_BW +: ACT_BW] = ACT_BW'(v.exp + l*v.estep);
    e.sat = v.esat[0];
    sb.push_back(e);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check({v.name, ".start_ready"}, 64'(o_ready), 64'(v.k != 0));
    junk_inputs();
    for (int e2 = 0; e2 < VEC; e2++) i_fmap[e2*I_F_BW +: I_F_BW] = I_F_BW'(v.f);
    beats = 0; guard = 0;
    while (beats < v.k && guard < 4000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_start = 1'(($urandom_range(0, 1)));
      @(negedge clk);
      if (i_valid && o_ready) beats++;
      guard++;
      @(posedge clk); #1;
    end
    check({v.name, ".beats"}, 64'(beats), 64'(v.k));
    // Anything presented after the last beat must be ignored.
    i_valid = 1'b1;
    i_fmap  = VEC*I_F_BW'({$urandom, $urandom});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 10);
    check({v.name, ".latency"}, 64'(lat), 64'd2);
    if (sb.size() == 0) begin
      check({v.name, ".scoreboard"}, 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check({v.name, ".data"}, 64'(o_act_data), 64'(got.data));
      check({v.name, ".sat"},  64'(o_sat),      64'(got.sat));
      for (int c = 0; c < v.bp; c++) begin
        @(negedge clk);
        check({v.name, ".bp_hold"}, 64'({o_valid, o_ready, o_sat, o_act_data}),
              64'({1'b1, 1'b0, got.sat, got.data}));
      end
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({v.name, ".done"}, 64'({o_busy, o_valid}), 64'd0);
  endtask

  initial begin
    tbl[0]  = mk("basic",      1,    1,    2,    3,  0,  0, 0,   0, 0,       13,  0, 0);
    tbl[1]  = mk("k0_bias",    0,    0,    0,   -4,  0,  0, 1,   0, 0,        0,  0, 0);
    tbl[2]  = mk("clip",       1,   10,   10,    0,  0,  0, 2,   6, 0,        6,  0, 0);
    tbl[3]  = mk("acc_sat",  255, -128, -128,    0,  0, 16, 0,   0, 3,      127,  0, 1);
    tbl[4]  = mk("round",      1,    1,    2,    0,  0,  2, 0,   0, 0,  RND_EXP,  0, 0);
    tbl[5]  = mk("neg_multi",  2,    3,   -4,    5,  0,  0, 0,   0, 1,     -115,  0, 0);
    tbl[6]  = mk("out_satn",   1,  100, -100,    0,  0,  0, 0,   0, 0,     -128,  0, 1);
    tbl[7]  = mk("mode3",      1,    2,    3,  -40,  0,  0, 3,   0, 0,      -10,  0, 0);
    tbl[8]  = mk("relu_pos",   1,    2,    3,    0,  0,  0, 1,   0, 0,       30,  0, 0);
    tbl[9]  = mk("ashr_neg",   1,   -1,    3,    0,  0,  2, 0,   0, 0,       -4,  0, 0);
    tbl[10] = mk("lane_bias",  1,    0,    0,  -20, 10,  0, 0,   0, 0,      -20, 10, 0);
    tbl[11] = mk("clip_neg",   3,   -2,    3,    0,  0,  0, 2,  50, 0,        0,  0, 0);
    tbl[12] = mk("clip_255",   1,   20,   20,    0,  0,  0, 2, 255, 0,      127,  0, 1);
    tbl[13] = mk("bias_shift", 4,    5,    5, -124,  0,  3, 0,   0, 0,       47,  0, 0);

    #12;
    check("reset_in", 64'({o_ready, o_valid, o_sat, o_busy, o_act_data}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_out", 64'({o_ready, o_valid, o_sat, o_busy, o_act_data}), 64'd0);

    for (int t = 0; t < 14; t++) run_job(tbl[t]);

    // Reset mid-ACC abandons the job; a following job is fresh.
    load_job(mk("abandon", 10, 7, 7, 50, 0, 0, 0, 0, 0, 0, 0, 0));
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", 64'({o_ready, o_valid, o_sat, o_busy, o_act_data}), 64'd0);
    i_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(tbl[0]);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
